// File: rtl/ram_sp_sync.sv
// ram_sp_sync: flip-flop single-port RAM with a registered, read-first output
// and an asynchronous clear of the whole array.
module ram_sp_sync #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] data_out
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    // Read samples the pre-write contents, so a same-address write returns old data
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            mem_d[i] = (write_enable && address == ADDR_WIDTH'(i)) ? data_in : mem_q[i];
        data_out_d = mem_q[address];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            data_out_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= mem_d[i];
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
endmodule

// File: tb/tb_ram_sp_sync.sv
// tb_ram_sp_sync: directed vectors for ram_sp_sync; inputs change and outputs
// are sampled on the falling edge.
module tb_ram_sp_sync;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] address = '0;
    logic [7:0] data_in = '0;
    logic       write_enable = 1'b0;
    logic [7:0] data_out;
    int         n_checks = 0;
    int         n_pass = 0;

    ram_sp_sync #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .address(address),
        .data_in(data_in),
        .write_enable(write_enable),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Called on a falling edge; returns on the next falling edge after one rising edge
    task automatic cyc(input logic [1:0] a, input logic [7:0] d, input logic we);
        address = a;
        data_in = d;
        write_enable = we;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2'd0, 8'h5C, 1'b1);
        cyc(2'd0, 8'h00, 1'b0);
        check("pre_reset_read", data_out, 8'h5C);
        #2 rst_n = 1'b0;
        #1 check("async_reset_clear", data_out, 8'h00);
        @(negedge clk);
        cyc(2'd0, 8'h77, 1'b1);
        check("reset_held_out", data_out, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(2'(i), 8'h00, 1'b0);
            check($sformatf("reset_read_%0d", i), data_out, 8'h00);
        end

        cyc(2'd0, 8'b10101010, 1'b1);
        cyc(2'd1, 8'b11110000, 1'b1);
        cyc(2'd0, 8'h00, 1'b0);
        check("rd_addr0", data_out, 8'b10101010);
        cyc(2'd1, 8'h00, 1'b0);
        check("rd_addr1", data_out, 8'b11110000);

        #1 rst_n = 1'b0;
        #1 check("midrun_reset_clear", data_out, 8'h00);
        #2 rst_n = 1'b1;
        @(negedge clk);
        cyc(2'd0, 8'h00, 1'b0);
        check("midrun_rd_addr0", data_out, 8'h00);
        cyc(2'd1, 8'h00, 1'b0);
        check("midrun_rd_addr1", data_out, 8'h00);

        cyc(2'd2, 8'h11, 1'b1);
        cyc(2'd2, 8'h22, 1'b1);
        check("collision_old", data_out, 8'h11);
        cyc(2'd2, 8'h00, 1'b0);
        check("collision_new", data_out, 8'h22);

        for (int i = 0; i < 4; i++) cyc(2'(i), 8'hA0 + 8'(i), 1'b1);
        cyc(2'd3, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(2'(i), 8'h00, 1'b0);
            check($sformatf("iso_rd_%0d", i), data_out, (i == 3) ? 8'hFF : 8'hA0 + 8'(i));
        end

        cyc(2'd0, 8'h00, 1'b0);
        check("lat_base", data_out, 8'hA0);
        address = 2'd1;
        #2 check("lat_hold", data_out, 8'hA0);
        address = 2'd2;
        #1 check("lat_hold2", data_out, 8'hA0);
        @(negedge clk);
        check("lat_new", data_out, 8'hA2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ram_sp_sync.md
Name: ram_sp_sync

Overview:
Single-port synchronous RAM built from flip-flops. Default size is 4 words x 8 bits. Writes and reads both happen on the rising clock edge, and the read data is registered. It is a small scratch/config store for control logic, and asynchronous reset clears the whole array.

Parameters:
- ADDR_WIDTH, 2, address width in bits; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 8, word width in bits

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- address  input  ADDR_WIDTH  word address for both read and write
- data_in  input  DATA_WIDTH  write data
- write_enable  input  1  1 = write data_in to mem[address] at the rising edge; 0 = read only
- data_out  output  DATA_WIDTH  registered read data

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Storage: array mem[0 .. 2**ADDR_WIDTH-1], each DATA_WIDTH bits, implemented as registers.
- Reset:
  - rst_n low immediately clears every mem entry and data_out to all zeros, with no dependence on clk.
  - Reset held low: all state stays zero, and writes are ignored.
  - Reset release is synchronous-safe: the first rising edge with rst_n high performs a normal access.
- Write:
  - On a rising edge with rst_n=1 and write_enable=1, mem[address] <= data_in.
  - Write latency is 1 edge.
  - No other entry changes.
- Read:
  - On every rising edge with rst_n=1, data_out <= mem[address].
  - The value is the array content before that edge's write (read-first).
  - Read latency is 1 cycle: data for an address presented before edge N appears after edge N.
  - data_out holds between edges.
- Write and read to the same address on the same edge: data_out gets the OLD contents; the new data is visible from the next edge.
- Address changes between edges have no effect until the next rising edge (no combinational path from address to data_out).
- Address range: every address value is valid, since depth equals 2**ADDR_WIDTH. There is no out-of-range case and no wrap logic.
- Reset mid-operation: an access in progress is discarded. Memory and data_out read zero after reset until rewritten.
- X-safety: with rst_n=1 and write_enable unknown, behaviour is undefined. Benches must drive write_enable to a known value.

Test Plan:
1. Reset clear:
   - Assert rst_n=0 asynchronously between edges -> data_out=8'h00 immediately.
   - After release, reading addresses 0..3 -> 8'h00 each.
2. Write/read back:
   - With write_enable=1, write address 0 = 8'b10101010, then address 1 = 8'b11110000.
   - With write_enable=0, read address 0 -> data_out=8'b10101010 one edge later; read address 1 -> 8'b11110000.
3. Read-first collision:
   - Address 2 holds 8'h11. Write 8'h22 to address 2 -> data_out=8'h11 after that edge.
   - Next edge with write_enable=0 -> 8'h22.
4. Isolation:
   - Fill addresses 0..3 with 8'hA0, 8'hA1, 8'hA2, 8'hA3, overwrite address 3 with 8'hFF.
   - Read all -> 8'hA0, 8'hA1, 8'hA2, 8'hFF.
5. Latency check:
   - Change address between edges -> data_out unchanged until the next rising edge, then shows the new word.
6. Mid-run reset:
   - After scenario 2, pulse rst_n low for 3 ns (not on an edge) -> data_out=8'h00 at once.
   - Subsequent reads of addresses 0 and 1 -> 8'h00.
